// File: rtl/display_scan_mux.sv
// Seven-segment digit scanner: double-buffered hex value, per-slot blanking,
// leading-zero suppression and frame-synchronous (tear-free) value updates.
module display_scan_mux #(
   parameter int DIGITS       = 4,
   parameter int PRESCALE     = 50000,
   parameter int BLANK_CYCLES = 500
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  load,
   input  logic [4*DIGITS-1:0]   data,
   input  logic                  lz_en,
   output logic [3:0]            bcd,
   output logic                  blank,
   output logic [DIGITS-1:0]     an,
   output logic                  frame_start,
   output logic                  upd_pend
);

   localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   logic [PW-1:0]         pre;
   logic [IW-1:0]         idx;
   logic [4*DIGITS-1:0]   shadow;
   logic [4*DIGITS-1:0]   active;
   logic                  pending;

   logic                  slot_wrap;
   logic                  boundary;
   logic [DIGITS-1:0]     supp;
   logic                  seen;
   logic [3:0]            nib;
   logic                  cur_supp;
   logic                  en;
   logic [DIGITS-1:0]     an_nxt;

   assign slot_wrap = (pre == PW'(PRESCALE - 1));
   assign boundary  = slot_wrap && (idx == IW'(DIGITS - 1));
   assign upd_pend  = pending;

   // Walk from the top digit down: a digit is suppressed while every nibble
   // at or above it is zero. Digit 0 always shows.
   always_comb begin
      supp = '0;
      seen = 1'b0;
      for (int k = DIGITS - 1; k >= 0; k--) begin
         seen = seen | (|active[4*k +: 4]);
         if (k != 0) supp[k] = lz_en & ~seen;
      end
   end

   always_comb begin
      nib      = 4'd0;
      cur_supp = 1'b0;
      for (int k = 0; k < DIGITS; k++) begin
         if (idx == IW'(k)) begin
            nib      = active[4*k +: 4];
            cur_supp = supp[k];
         end
      end
      en = !cur_supp && (int'(pre) >= BLANK_CYCLES);
      for (int k = 0; k < DIGITS; k++) an_nxt[k] = en && (idx == IW'(k));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pre     <= '0;
         idx     <= '0;
         shadow  <= '0;
         active  <= '0;
         pending <= 1'b0;
      end else begin
         pre <= slot_wrap ? '0 : pre + PW'(1);
         if (slot_wrap) idx <= (idx == IW'(DIGITS - 1)) ? '0 : idx + IW'(1);
         if (load) shadow <= data;
         if (boundary) begin
            // A load landing on the boundary goes straight to the display.
            if (load)         active <= data;
            else if (pending) active <= shadow;
            pending <= 1'b0;
         end else if (load) begin
            pending <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         bcd         <= 4'd0;
         blank       <= 1'b1;
         an          <= '0;
         frame_start <= 1'b0;
      end else begin
         bcd         <= cur_supp ? 4'd0 : nib;
         blank       <= ~en;
         an          <= an_nxt;
         frame_start <= (pre == '0) && (idx == '0);
      end
   end

endmodule
